// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared CPU memory-access definitions.
// Access FSM state encoding and default data width / ack timeout.
package mem_access_unit_pkg;

  localparam int MAU_WIDTH   = 32;
  localparam int MAU_TIMEOUT = 15;

  typedef enum logic [1:0] {
    MAU_IDLE,
    MAU_REQ,
    MAU_DONE,
    MAU_ERR
  } mau_state_e;

endpackage

// File: rtl/mem_edge_det.sv
// mem_edge_det: per-bit rising-edge detector for controller levels.
// Ports: clk, reset (sync, active-high), sig (levels), rise (edge pulses).
module mem_edge_det #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sig,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev_q, prev_d;
  logic [N-1:0] lock_q, lock_d;

  // A level still high across reset stays locked out until it drops,
  // so it cannot look like a fresh edge once reset is released.
  always_comb begin
    prev_d = sig;
    lock_d = lock_q & sig;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      lock_q <= sig;
    end else begin
      prev_q <= prev_d;
      lock_q <= lock_d;
    end
  end

  assign rise = sig & ~prev_q & ~lock_q;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR plus one-access-at-a-time RAM handshake FSM.
// Ports: controller strobes in, RAM req/we/addr/wdata out, rdData/mdrOut/status out.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WIDTH   = MAU_WIDTH,
  parameter int TIMEOUT = MAU_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             marEn,
  input  logic             pcFetch,
  input  logic             mdrEn,
  input  logic             ldEn,
  input  logic             stEn,
  input  logic             rd,
  input  logic             wr,
  input  logic [WIDTH-1:0] pcIn,
  input  logic [WIDTH-1:0] addrIn,
  input  logic [WIDTH-1:0] stData,
  output logic [WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0] memWdata,
  output logic             memReq,
  output logic             memWe,
  input  logic [WIDTH-1:0] memRdata,
  input  logic             memAck,
  output logic [WIDTH-1:0] rdData,
  output logic [WIDTH-1:0] mdrOut,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  mau_state_e       state_q, state_d;
  logic [WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] addr_lat_q, addr_lat_d;
  logic [WIDTH-1:0] wdata_lat_q, wdata_lat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;
  logic [1:0]       rise;
  logic             in_req;

  mem_edge_det #(.N(2)) u_edge (
    .clk   (clk),
    .reset (reset),
    .sig   ({wr, rd}),
    .rise  (rise)
  );

  always_comb begin
    mar_d = mar_q;
    if (marEn) mar_d = pcFetch ? pcIn : addrIn;
    mdr_d = mdr_q;
    if (mdrEn) begin
      if (stEn)      mdr_d = stData;
      else if (ldEn) mdr_d = rd_data_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    rd_data_d   = rd_data_q;
    addr_lat_d  = addr_lat_q;
    wdata_lat_d = wdata_lat_q;
    case (state_q)
      MAU_IDLE: begin
        if (rise[0] && rise[1]) begin
          state_d = MAU_ERR;
        end else if (rise[0] || rise[1]) begin
          state_d = MAU_REQ;
          is_wr_d = rise[1];
          cnt_d   = '0;
          // Snapshot what MAR/MDR hold in the first REQ cycle so
          // later loads cannot disturb the access in flight.
          addr_lat_d  = mar_d;
          wdata_lat_d = mdr_d;
        end
      end
      MAU_REQ: begin
        if (memAck) begin
          state_d = MAU_DONE;
          if (!is_wr_q) rd_data_d = memRdata;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = MAU_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MAU_DONE: state_d = MAU_IDLE;
      MAU_ERR: begin
        if (!rd && !wr) state_d = MAU_IDLE;
      end
      default: state_d = MAU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MAU_IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      rd_data_q   <= '0;
      addr_lat_q  <= '0;
      wdata_lat_q <= '0;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      rd_data_q   <= rd_data_d;
      addr_lat_q  <= addr_lat_d;
      wdata_lat_q <= wdata_lat_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
    end
  end

  // Status is gated by reset so nothing is asserted while it is held.
  assign in_req   = (state_q == MAU_REQ) && !reset;
  assign memReq   = in_req;
  assign busy     = in_req;
  assign memWe    = in_req && is_wr_q;
  assign done     = (state_q == MAU_DONE) && !reset;
  assign err      = (state_q == MAU_ERR) && !reset;
  assign memAddr  = (state_q == MAU_REQ) ? addr_lat_q : mar_q;
  assign memWdata = (state_q == MAU_REQ) ? wdata_lat_q : mdr_q;
  assign rdData   = rd_data_q;
  assign mdrOut   = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scenario tasks plus randomized accesses checked
// against a transaction-level model of MAR/MDR/rdData and access outcome.
module tb_mem_access_unit;

  localparam int T   = 15;
  localparam int WIN = T + 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        marEn = 0, pcFetch = 0, mdrEn = 0, ldEn = 0, stEn = 0;
  logic        rd = 0, wr = 0, memAck = 0;
  logic [31:0] pcIn = 0, addrIn = 0, stData = 0, memRdata = 0;
  logic [31:0] memAddr, memWdata, rdData, mdrOut;
  logic        memReq, memWe, busy, done, err;

  int vecs = 0;
  int errs = 0;

  logic [31:0] m_mar = 0, m_mdr = 0, m_rd = 0;
  int o_req, o_we, o_done, o_err, o_bad;

  mem_access_unit #(.WIDTH(32), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .marEn(marEn), .pcFetch(pcFetch), .mdrEn(mdrEn),
    .ldEn(ldEn), .stEn(stEn), .rd(rd), .wr(wr),
    .pcIn(pcIn), .addrIn(addrIn), .stData(stData),
    .memAddr(memAddr), .memWdata(memWdata),
    .memReq(memReq), .memWe(memWe),
    .memRdata(memRdata), .memAck(memAck),
    .rdData(rdData), .mdrOut(mdrOut),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input bit pcf, input logic [31:0] pc,
                          input logic [31:0] ad);
    marEn = 1; pcFetch = pcf; pcIn = pc; addrIn = ad;
    step();
    marEn = 0; pcFetch = 0;
    m_mar = pcf ? pc : ad;
  endtask

  task automatic load_mdr(input bit st, input bit ld,
                          input logic [31:0] sd);
    mdrEn = 1; stEn = st; ldEn = ld; stData = sd;
    step();
    mdrEn = 0; stEn = 0; ldEn = 0;
    if (st) m_mdr = sd;
    else if (ld) m_mdr = m_rd;
  endtask

  // Raises rd or wr, then watches a fixed window; memAck is offered on
  // window cycle ack_at (0 = never). MAR may be reloaded mid-access.
  task automatic run_access(input bit is_wr, input int ack_at,
                            input logic [31:0] rdat, input bit remar,
                            input logic [31:0] nad);
    logic [31:0] fa, fw;
    fa = m_mar; fw = m_mdr;
    o_req = 0; o_we = 0; o_done = 0; o_err = 0; o_bad = 0;
    if (is_wr) wr = 1; else rd = 1;
    step();
    for (int i = 1; i <= WIN; i++) begin
      if (memReq === 1'b1) begin
        o_req++;
        if (memWe === 1'b1) o_we++;
        if (memAddr !== fa || memWdata !== fw) o_bad++;
      end
      if (done === 1'b1) o_done++;
      if (err === 1'b1) o_err++;
      memAck = (i == ack_at);
      memRdata = (i == ack_at) ? rdat : $urandom;
      if (remar && i == 2) begin
        marEn = 1; addrIn = nad;
      end else begin
        marEn = 0;
      end
      step();
    end
    memAck = 0; marEn = 0;
    if (remar) m_mar = nad;
  endtask

  task automatic test_reset();
    reset = 1;
    step(); step();
    vecs++; if ({memReq, memWe, busy, done, err} !== 5'b0) begin errs++;
      $display("FAIL reset_status got %b exp 00000", {memReq, memWe, busy, done, err}); end
    vecs++; if (memAddr !== 32'h0) begin errs++;
      $display("FAIL reset_memAddr got %h exp 0", memAddr); end
    vecs++; if (memWdata !== 32'h0) begin errs++;
      $display("FAIL reset_memWdata got %h exp 0", memWdata); end
    vecs++; if (rdData !== 32'h0) begin errs++;
      $display("FAIL reset_rdData got %h exp 0", rdData); end
    vecs++; if (mdrOut !== 32'h0) begin errs++;
      $display("FAIL reset_mdrOut got %h exp 0", mdrOut); end
    reset = 0;
    m_mar = 0; m_mdr = 0; m_rd = 0;
    step();
  endtask

  task automatic test_fetch();
    load_mar(1, 32'h10, $urandom);
    run_access(0, 3, 32'hDEADBEEF, 0, 0);
    m_rd = 32'hDEADBEEF;
    vecs++; if (o_req !== 3) begin errs++;
      $display("FAIL fetch_req_cycles got %0d exp 3", o_req); end
    vecs++; if (o_we !== 0) begin errs++;
      $display("FAIL fetch_memWe got %0d exp 0", o_we); end
    vecs++; if (o_bad !== 0) begin errs++;
      $display("FAIL fetch_addr_frozen got %0d bad exp 0", o_bad); end
    vecs++; if (o_done !== 1) begin errs++;
      $display("FAIL fetch_done got %0d exp 1", o_done); end
    vecs++; if (rdData !== 32'hDEADBEEF) begin errs++;
      $display("FAIL fetch_rdData got %h exp deadbeef", rdData); end
    vecs++; if (memAddr !== 32'h10) begin errs++;
      $display("FAIL fetch_memAddr got %h exp 10", memAddr); end
    rd = 0;
    step();
  endtask

  task automatic test_store();
    load_mdr(1, 0, 32'h1234);
    load_mar(0, $urandom, 32'h40);
    run_access(1, 2, $urandom, 0, 0);
    vecs++; if (o_req !== 2 || o_we !== 2) begin errs++;
      $display("FAIL store_req_we got %0d/%0d exp 2/2", o_req, o_we); end
    vecs++; if (o_bad !== 0) begin errs++;
      $display("FAIL store_addr_wdata got %0d bad exp 0", o_bad); end
    vecs++; if (o_done !== 1) begin errs++;
      $display("FAIL store_done got %0d exp 1", o_done); end
    vecs++; if (memWdata !== 32'h1234 || memAddr !== 32'h40) begin errs++;
      $display("FAIL store_bus got %h/%h exp 40/1234", memAddr, memWdata); end
    vecs++; if (rdData !== m_rd) begin errs++;
      $display("FAIL store_rdData got %h exp %h", rdData, m_rd); end
    wr = 0;
    step();
  endtask

  task automatic test_load();
    logic [31:0] v;
    load_mar(0, $urandom, 32'h44);
    run_access(0, 1, 32'hCAFE, 0, 0);
    m_rd = 32'hCAFE;
    rd = 0;
    step();
    vecs++; if (o_done !== 1 || memAddr !== 32'h44) begin errs++;
      $display("FAIL load_access got done=%0d addr=%h exp 1/44", o_done, memAddr); end
    load_mdr(0, 1, $urandom);
    vecs++; if (mdrOut !== 32'hCAFE) begin errs++;
      $display("FAIL load_mdrOut got %h exp cafe", mdrOut); end
    v = $urandom;
    load_mdr(1, 1, v);
    vecs++; if (mdrOut !== v) begin errs++;
      $display("FAIL load_st_wins got %h exp %h", mdrOut, v); end
    load_mdr(0, 0, $urandom);
    vecs++; if (mdrOut !== v) begin errs++;
      $display("FAIL load_mdr_hold got %h exp %h", mdrOut, v); end
  endtask

  task automatic test_timeout();
    load_mar(0, $urandom, $urandom);
    run_access(0, 0, 0, 0, 0);
    vecs++; if (o_req !== T + 1) begin errs++;
      $display("FAIL timeout_req_cycles got %0d exp %0d", o_req, T + 1); end
    vecs++; if (o_done !== 0) begin errs++;
      $display("FAIL timeout_done got %0d exp 0", o_done); end
    vecs++; if (o_err !== WIN - (T + 1) || err !== 1'b1) begin errs++;
      $display("FAIL timeout_err got %0d/%b exp %0d/1", o_err, err, WIN - (T + 1)); end
    vecs++; if (rdData !== m_rd) begin errs++;
      $display("FAIL timeout_rdData got %h exp %h", rdData, m_rd); end
    rd = 0;
    step();
    vecs++; if (err !== 1'b0 || busy !== 1'b0) begin errs++;
      $display("FAIL timeout_exit got err=%b busy=%b exp 0/0", err, busy); end
  endtask

  task automatic test_reset_mid_req();
    int n_req;
    reset = 1;
    step();
    reset = 0;
    m_mar = 0; m_mdr = 0; m_rd = 0;
    step();
    rd = 1;
    step();
    vecs++; if (memReq !== 1'b1) begin errs++;
      $display("FAIL rst_req_start got %b exp 1", memReq); end
    reset = 1;
    #1;
    vecs++; if ({memReq, busy, memWe} !== 3'b0) begin errs++;
      $display("FAIL rst_during got %b exp 000", {memReq, busy, memWe}); end
    step();
    reset = 0; memAck = 1; memRdata = $urandom;
    step();
    memAck = 0;
    vecs++; if ({memReq, memWe, busy, done, err} !== 5'b0) begin errs++;
      $display("FAIL rst_after got %b exp 00000", {memReq, memWe, busy, done, err}); end
    vecs++; if (rdData !== 32'h0) begin errs++;
      $display("FAIL rst_rdData got %h exp 0", rdData); end
    n_req = 0;
    for (int i = 0; i < 5; i++) begin
      if (memReq !== 1'b0 || done !== 1'b0) n_req++;
      step();
    end
    vecs++; if (n_req !== 0) begin errs++;
      $display("FAIL rst_held_rd got %0d active exp 0", n_req); end
    rd = 0;
    step();
    rd = 1;
    step();
    vecs++; if (memReq !== 1'b1) begin errs++;
      $display("FAIL rst_retoggle got %b exp 1", memReq); end
    memAck = 1; memRdata = 32'h0BADF00D;
    step();
    memAck = 0;
    m_rd = 32'h0BADF00D;
    vecs++; if (done !== 1'b1 || rdData !== m_rd) begin errs++;
      $display("FAIL rst_recover got done=%b rd=%h exp 1/%h", done, rdData, m_rd); end
    rd = 0;
    step();
  endtask

  task automatic test_collision();
    int n_req, n_err;
    rd = 1; wr = 1;
    step();
    vecs++; if (err !== 1'b1 || memReq !== 1'b0) begin errs++;
      $display("FAIL coll_enter got err=%b req=%b exp 1/0", err, memReq); end
    n_req = 0; n_err = 0;
    for (int i = 0; i < 4; i++) begin
      if (memReq !== 1'b0) n_req++;
      if (err === 1'b1) n_err++;
      step();
    end
    vecs++; if (n_req !== 0 || n_err !== 4) begin errs++;
      $display("FAIL coll_hold got req=%0d err=%0d exp 0/4", n_req, n_err); end
    rd = 0;
    step();
    vecs++; if (err !== 1'b1) begin errs++;
      $display("FAIL coll_wr_still got err=%b exp 1", err); end
    wr = 0;
    step();
    vecs++; if (err !== 1'b0 || memReq !== 1'b0) begin errs++;
      $display("FAIL coll_exit got err=%b req=%b exp 0/0", err, memReq); end
  endtask

  task automatic test_random();
    bit iw, rm, ok;
    int ack, e_req;
    logic [31:0] d, na;
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1)
        load_mar(bit'($urandom_range(0, 1)), $urandom, $urandom);
      if ($urandom_range(0, 1) == 1)
        load_mdr(1, 0, $urandom);
      iw = bit'($urandom_range(0, 1));
      rm = bit'($urandom_range(0, 1));
      ack = $urandom_range(0, T + 3);
      d = $urandom; na = $urandom;
      ok = (ack >= 1 && ack <= T + 1);
      e_req = ok ? ack : T + 1;
      run_access(iw, ack, d, rm, na);
      if (ok && !iw) m_rd = d;
      vecs++; if (o_req !== e_req || o_we !== (iw ? e_req : 0)) begin errs++;
        $display("FAIL rnd%0d_req_we got %0d/%0d exp %0d/%0d", k, o_req, o_we,
                 e_req, iw ? e_req : 0); end
      vecs++; if (o_done !== (ok ? 1 : 0) || o_err !== (ok ? 0 : WIN - (T + 1))) begin errs++;
        $display("FAIL rnd%0d_status got done=%0d err=%0d ack=%0d", k, o_done, o_err, ack); end
      vecs++; if (o_bad !== 0) begin errs++;
        $display("FAIL rnd%0d_frozen got %0d bad exp 0", k, o_bad); end
      vecs++; if (rdData !== m_rd || memAddr !== m_mar || memWdata !== m_mdr) begin errs++;
        $display("FAIL rnd%0d_regs got %h/%h/%h exp %h/%h/%h", k, rdData, memAddr,
                 memWdata, m_rd, m_mar, m_mdr); end
      rd = 0; wr = 0;
      step();
      vecs++; if (err !== 1'b0 || busy !== 1'b0) begin errs++;
        $display("FAIL rnd%0d_idle got err=%b busy=%b exp 0/0", k, err, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_load();
    test_timeout();
    test_reset_mid_req();
    test_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
